// File: rtl/puf_uart_framer.sv
// puf_uart_framer: UART command front-end for a PUF.
// Command 0x01 followed by a challenge byte triggers one PUF evaluation.
// The response is returned as a framed byte stream on the UART TX handshake:
//   good  : HEADER, challenge, response bytes (MSB first), XOR checksum
//   error : ERR_HEADER, challenge   (no response within TIMEOUT_CYCLES)
module puf_uart_framer #(
  parameter int          RESP_BYTES     = 2,
  parameter int          CHAL_BITS      = 4,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  ERR_HEADER     = 8'h5A,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk_100MHz,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    puf_start,
  output logic [CHAL_BITS-1:0]    challenge,
  input  logic                    puf_done,
  input  logic [8*RESP_BYTES-1:0] puf_resp,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [15:0]             frame_count
);

  localparam int FLEN = RESP_BYTES + 3;
  localparam int IW   = $clog2(FLEN);
  // The wait counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, GET_CHAL, EVAL, WAIT_RESP, LOAD, SEND, WAIT_TX
  } state_t;

  state_t                 state;
  logic [FLEN-1:0][7:0]   frame_buf;
  logic [FLEN-1:0][7:0]   good_frame;
  logic [IW-1:0]          byte_idx;
  logic [IW-1:0]          last_idx;
  logic [TW-1:0]          wait_cnt;
  logic                   frame_good;
  logic [7:0]             chal_byte;
  logic [7:0]             csum;

  // Challenge zero-extended to a full byte for the frame.
  always_comb begin
    chal_byte = '0;
    chal_byte[CHAL_BITS-1:0] = challenge;
  end

  // Checksum over header, challenge and response bytes, plain 8-bit XOR.
  always_comb begin
    csum = HEADER ^ chal_byte;
    for (int i = 0; i < RESP_BYTES; i++)
      csum = csum ^ puf_resp[8*(RESP_BYTES-i)-1 -: 8];
  end

  // Good frame assembled straight from the live response so it can be
  // captured in the same cycle puf_done is seen.
  always_comb begin
    good_frame    = '0;
    good_frame[0] = HEADER;
    good_frame[1] = chal_byte;
    for (int i = 0; i < RESP_BYTES; i++)
      good_frame[2+i] = puf_resp[8*(RESP_BYTES-i)-1 -: 8];
    good_frame[FLEN-1] = csum;
  end

  // Main control FSM; every output is a register written here.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state       <= IDLE;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      puf_start   <= 1'b0;
      challenge   <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      frame_count <= '0;
      frame_buf   <= '0;
      byte_idx    <= '0;
      last_idx    <= '0;
      wait_cnt    <= '0;
      frame_good  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid && rx_data == 8'h01) begin
            state <= GET_CHAL;
            busy  <= 1'b1;
          end
        end
        GET_CHAL: begin
          // Any byte here is the challenge, including another 0x01.
          if (rx_valid) begin
            challenge   <= rx_data[CHAL_BITS-1:0];
            err_timeout <= 1'b0;
            puf_start   <= 1'b1;
            state       <= EVAL;
          end
        end
        EVAL: begin
          puf_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT_RESP;
        end
        WAIT_RESP: begin
          // puf_done is checked first so it wins over a same-cycle timeout.
          if (puf_done) begin
            frame_buf  <= good_frame;
            last_idx   <= IW'(FLEN-1);
            frame_good <= 1'b1;
            byte_idx   <= '0;
            state      <= LOAD;
          end else if (wait_cnt == TW'(TIMEOUT_CYCLES-1)) begin
            err_timeout  <= 1'b1;
            frame_buf    <= '0;
            frame_buf[0] <= ERR_HEADER;
            frame_buf[1] <= chal_byte;
            last_idx     <= IW'(1);
            frame_good   <= 1'b0;
            byte_idx     <= '0;
            state        <= LOAD;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        LOAD: begin
          // Only place tx_data changes; tx_start is low here.
          tx_data <= frame_buf[byte_idx];
          state   <= SEND;
        end
        SEND: begin
          if (tx_start && tx_busy) begin
            tx_start <= 1'b0;
            state    <= WAIT_TX;
          end else if (!tx_start && !tx_busy) begin
            tx_start <= 1'b1;
          end
        end
        WAIT_TX: begin
          if (!tx_busy) begin
            if (byte_idx == last_idx) begin
              if (frame_good) frame_count <= frame_count + 16'd1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + IW'(1);
              state    <= LOAD;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          tx_start  <= 1'b0;
          puf_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_uart_framer.sv
// Bench for puf_uart_framer: a UART TX model records every accepted byte,
// expected frames are queued when the PUF response is driven and popped
// against recorded bytes.
module tb_puf_uart_framer;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        puf_start;
  logic [3:0]  challenge;
  logic        puf_done = 1'b0;
  logic [15:0] puf_resp = '0;
  logic        busy;
  logic        err_timeout;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int tx_dly = 1;
  int tx_hold = 3;
  int exp_fc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk_100MHz = ~clk_100MHz;

  puf_uart_framer #(
    .RESP_BYTES(2), .CHAL_BITS(4), .HEADER(8'hA5), .ERR_HEADER(8'h5A),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_100MHz(clk_100MHz), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .puf_start(puf_start), .challenge(challenge),
    .puf_done(puf_done), .puf_resp(puf_resp),
    .busy(busy), .err_timeout(err_timeout), .frame_count(frame_count)
  );

  // UART TX model: accepts a request tx_dly cycles after seeing it (aborts
  // if the request is withdrawn), then stays busy for tx_hold cycles.
  always begin : tx_model
    logic [7:0] d;
    bit ok;
    @(negedge clk_100MHz);
    if (tx_start === 1'b1 && tx_busy === 1'b0) begin
      d  = tx_data;
      ok = 1'b1;
      for (int k = 0; k < tx_dly; k++) begin
        @(negedge clk_100MHz);
        if (tx_start !== 1'b1) begin
          ok = 1'b0;
          break;
        end
      end
      if (ok) begin
        tx_busy = 1'b1;
        n_cmp++;
        if (tx_data !== d) begin
          n_err++;
          $display("FAIL tx_data_stable: got %h required %h", tx_data, d);
        end
        got_q.push_back(d);
        repeat (tx_hold) @(negedge clk_100MHz);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_100MHz);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk_100MHz);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [15:0] r);
    @(negedge clk_100MHz);
    puf_done = 1'b1; puf_resp = r;
    @(negedge clk_100MHz);
    puf_done = 1'b0;
  endtask

  task automatic push_good(input logic [7:0] c, input logic [15:0] r);
    logic [7:0] cs;
    cs = 8'hA5 ^ c ^ r[15:8] ^ r[7:0];
    exp_q.push_back(8'hA5); exp_q.push_back(c);
    exp_q.push_back(r[15:8]); exp_q.push_back(r[7:0]); exp_q.push_back(cs);
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    for (int c = 0; c < 3000 && got_q.size() < n; c++) @(negedge clk_100MHz);
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    for (int c = 0; c < 3000 && busy !== 1'b0; c++) @(negedge clk_100MHz);
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    n_cmp++;
    if ({tx_data, tx_start, puf_start, challenge, busy, err_timeout, frame_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h start=%b pstart=%b chal=%h busy=%b err=%b fc=%0d required all 0",
               tx_data, tx_start, puf_start, challenge, busy, err_timeout, frame_count);
    end
    rst = 1'b0;
    exp_fc = 0;
  endtask

  task automatic test_good_frame;
    bit ok;
    logic [7:0] g, e;
    send_byte(8'h01);
    send_byte(8'h0B);
    n_cmp++;
    if (puf_start !== 1'b1) begin n_err++; $display("FAIL puf_start: got %b required 1", puf_start); end
    @(negedge clk_100MHz);
    n_cmp++;
    if (puf_start !== 1'b0) begin n_err++; $display("FAIL puf_start_pulse: got %b required 0", puf_start); end
    repeat (5) @(negedge clk_100MHz);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h0B); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(8'h88);
    pulse_done(16'h1234);
    exp_fc++;
    wait_bytes(5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL good_count: got %0d bytes required 5", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL good_byte: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL good_busy: got %b required 0", busy); end
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL good_fc: got %0d required %0d", frame_count, exp_fc); end
  endtask

  task automatic test_chal_mask;
    bit ok;
    logic [7:0] g, e;
    logic [15:0] r;
    r = 16'($urandom);
    send_byte(8'h01);
    send_byte(8'hFB);
    n_cmp++;
    if (challenge !== 4'hB) begin n_err++; $display("FAIL chal_mask: got %h required b", challenge); end
    push_good(8'h0B, r);
    pulse_done(r);
    exp_fc++;
    wait_bytes(5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mask_count: got %0d bytes required 5", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL mask_byte: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    wait_idle(ok);
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL mask_fc: got %0d required %0d", frame_count, exp_fc); end
  endtask

  task automatic test_timeout;
    bit ok;
    logic [7:0] g, e;
    logic [15:0] r;
    exp_q.push_back(8'h5A); exp_q.push_back(8'h0B);
    send_byte(8'h01);
    send_byte(8'h0B);
    repeat (100) @(negedge clk_100MHz);
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b required 0", err_timeout); end
    @(negedge clk_100MHz);
    n_cmp++;
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b required 1", err_timeout); end
    wait_bytes(2, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL err_count: got %0d bytes required 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL err_byte: got %h required %h", g, e); end
    end
    wait_idle(ok);
    repeat (20) @(negedge clk_100MHz);
    n_cmp++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL err_extra: got %0d extra bytes required 0", got_q.size()); end
    got_q.delete(); exp_q.delete();
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL err_fc: got %0d required %0d", frame_count, exp_fc); end
    send_byte(8'h01);
    n_cmp++;
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b required 1", err_timeout); end
    send_byte(8'h03);
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b required 0", err_timeout); end
    r = 16'($urandom);
    push_good(8'h03, r);
    pulse_done(r);
    exp_fc++;
    wait_bytes(5, ok);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL after_err_byte: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    wait_idle(ok);
  endtask

  task automatic test_slow_tx;
    bit ok;
    logic [7:0] g, e;
    tx_dly = 3; tx_hold = 50;
    send_byte(8'h01);
    send_byte(8'h0C);
    push_good(8'h0C, 16'hBEEF);
    pulse_done(16'hBEEF);
    exp_fc++;
    wait_bytes(5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL slow_count: got %0d bytes required 5", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL slow_byte: got %h required %h", g, e); end
    end
    wait_idle(ok);
    repeat (20) @(negedge clk_100MHz);
    n_cmp++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL slow_dup: got %0d extra bytes required 0", got_q.size()); end
    got_q.delete(); exp_q.delete();
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL slow_fc: got %0d required %0d", frame_count, exp_fc); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [7:0] g, e;
    tx_dly = 3; tx_hold = 5;
    send_byte(8'h01);
    send_byte(8'h0B);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h0B);
    pulse_done(16'h1234);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_100MHz);
      if (got_q.size() == 2 && tx_start === 1'b1) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mid_third: got %0d bytes start=%b required 2 and 1", got_q.size(), tx_start); end
    rst = 1'b1;
    @(negedge clk_100MHz);
    n_cmp++;
    if (tx_start !== 1'b0) begin n_err++; $display("FAIL mid_start: got %b required 0", tx_start); end
    n_cmp++;
    if ({tx_data, puf_start, challenge, busy, err_timeout, frame_count} !== '0) begin
      n_err++;
      $display("FAIL mid_outputs: got data=%h pstart=%b chal=%h busy=%b err=%b fc=%0d required all 0",
               tx_data, puf_start, challenge, busy, err_timeout, frame_count);
    end
    rst = 1'b0;
    exp_fc = 0;
    repeat (20) @(negedge clk_100MHz);
    n_cmp++;
    if (got_q.size() != 2) begin n_err++; $display("FAIL mid_partial: got %0d bytes required 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL mid_byte: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    send_byte(8'h01);
    send_byte(8'h0B);
    push_good(8'h0B, 16'h1234);
    pulse_done(16'h1234);
    exp_fc++;
    wait_bytes(5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mid_new_count: got %0d bytes required 5", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL mid_new_byte: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    wait_idle(ok);
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin n_err++; $display("FAIL mid_fc: got %0d required %0d", frame_count, exp_fc); end
  endtask

  task automatic test_stray_coincident;
    bit ok;
    logic [7:0] g, e;
    tx_dly = 1; tx_hold = 3;
    send_byte(8'h7F);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL stray_7f: got busy %b required 0", busy); end
    send_byte(8'h00);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL stray_00: got busy %b required 0", busy); end
    send_byte(8'h01);
    send_byte(8'h05);
    // Bytes during WAIT_RESP, then puf_done on the final timeout cycle.
    send_byte(8'h01);
    send_byte(8'h22);
    repeat (96) @(negedge clk_100MHz);
    push_good(8'h05, 16'hC3A7);
    puf_done = 1'b1; puf_resp = 16'hC3A7;
    @(negedge clk_100MHz);
    puf_done = 1'b0;
    exp_fc++;
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL coinc_err: got %b required 0", err_timeout); end
    n_cmp++;
    if (challenge !== 4'h5) begin n_err++; $display("FAIL wait_rx_ignored: got %h required 5", challenge); end
    wait_bytes(5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL coinc_count: got %0d bytes required 5", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL coinc_byte: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    wait_idle(ok);
    n_cmp++;
    if (frame_count !== 16'(exp_fc) || err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL coinc_final: got fc=%0d err=%b required fc=%0d err=0", frame_count, err_timeout, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_chal_mask();
    test_timeout();
    test_slow_tx();
    test_reset_mid();
    test_stray_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/puf_uart_framer.md
PUF_UART_FRAMER -- requirements
Module: puf_uart_framer

Interface
REQ-001 SHALL have parameter RESP_BYTES, default 2, the PUF response width in bytes (1..8).
REQ-002 SHALL have parameter CHAL_BITS, default 4, the challenge width in bits (1..8).
REQ-003 SHALL have parameter HEADER, default 8'hA5, the good-frame header byte.
REQ-004 SHALL have parameter ERR_HEADER, default 8'h5A, the error-frame header byte.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum cycles spent waiting for puf_done.
REQ-006 SHALL have ports: clk_100MHz input 1 (system clock); rst input 1 (reset).
REQ-007 SHALL have ports: rx_data input 8 (received byte); rx_valid input 1 (one-cycle strobe, rx_data valid).
REQ-008 SHALL have ports: tx_data output 8 (byte to send); tx_start output 1 (send request, level); tx_busy input 1 (UART TX busy).
REQ-009 SHALL have ports: puf_start output 1 (evaluate pulse); challenge output CHAL_BITS; puf_done input 1; puf_resp input 8*RESP_BYTES.
REQ-010 SHALL have ports: busy output 1 (high in every state except IDLE); err_timeout output 1 (sticky); frame_count output 16 (count of good frames sent).
REQ-011 SHALL use one clock, clk_100MHz; rst SHALL be synchronous and active-high.

Function
REQ-012 SHALL implement the FSM states IDLE, GET_CHAL, EVAL, WAIT_RESP, LOAD, SEND, WAIT_TX.
REQ-013 In IDLE, SHALL move to GET_CHAL on rx_valid with rx_data==8'h01; any other byte SHALL be ignored.
REQ-014 In GET_CHAL, on rx_valid SHALL latch challenge = rx_data[CHAL_BITS-1:0] and clear err_timeout.
REQ-015 In GET_CHAL, on that same rx_valid SHALL go to EVAL; a second byte 8'h01 SHALL be treated as the challenge value, not as a restart.
REQ-016 EVAL SHALL last exactly one cycle with puf_start=1, so puf_start goes high in the cycle after the challenge byte is accepted; then go to WAIT_RESP.
REQ-017 WAIT_RESP SHALL count cycles; on puf_done it SHALL capture puf_resp and build a good frame.
REQ-018 Good frame, in order: HEADER, zero-extended challenge byte, response bytes MSB byte first, then checksum = XOR of all preceding frame bytes. Total length is RESP_BYTES+3.
REQ-019 If the count reaches TIMEOUT_CYCLES without puf_done, SHALL set err_timeout=1 and build an error frame: ERR_HEADER, challenge byte. Length 2, no checksum.
REQ-020 If puf_done and the timeout occur in the same cycle, puf_done SHALL win.
REQ-021 Frame bytes SHALL be held in a byte buffer indexed by a byte counter; LOAD SHALL present the current byte on tx_data.
REQ-022 In SEND, SHALL raise tx_start only when tx_busy==0, hold tx_start=1 and tx_data stable until tx_busy is sampled 1, then drop tx_start and go to WAIT_TX.
REQ-023 WAIT_TX SHALL wait for tx_busy==0, then advance the byte counter.
REQ-024 After the last byte, frame_count SHALL increment (wrapping 16'hFFFF->0) if the frame was good, and the FSM SHALL return to IDLE; otherwise it SHALL go to LOAD for the next byte.
REQ-025 rx_valid SHALL be ignored in EVAL, WAIT_RESP, LOAD, SEND and WAIT_TX.
REQ-026 puf_done outside WAIT_RESP SHALL be ignored.
REQ-027 tx_data SHALL change only in LOAD, never while tx_start=1.
REQ-028 The checksum SHALL be computed at full 8-bit width with no carry.

Reset
REQ-029 On rst at a clk_100MHz edge, the FSM SHALL go to IDLE and all outputs SHALL be 0: tx_data, tx_start, puf_start, challenge, busy, err_timeout, frame_count.
REQ-030 The byte counter, timeout counter and frame buffer SHALL clear on rst.
REQ-031 rst mid-frame SHALL abort transmission: tx_start=0 on the next edge, no further bytes sent, and frame_count unchanged.
REQ-032 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-033 Bench SHALL cover: RESP_BYTES=2; rx bytes 01, 0B; puf_done with puf_resp=16'h1234 -> tx sequence A5 0B 12 34 88; frame_count=1; busy low afterwards.
REQ-034 Bench SHALL cover: rx bytes 01, FB with CHAL_BITS=4 -> challenge=4'hB; second frame byte 0B.
REQ-035 Bench SHALL cover: TIMEOUT_CYCLES=100, puf_done never asserted -> err_timeout=1 at cycle 100 of WAIT_RESP; tx sequence 5A 0B; frame_count unchanged; the next command clears err_timeout.
REQ-036 Bench SHALL cover: tx_busy held high 50 cycles after each tx_start and TX modelled slow (busy rises 3 cycles after request) -> tx_start held until busy seen; no byte lost or duplicated.
REQ-037 Bench SHALL cover: rst asserted during the 3rd byte of a frame -> tx_start=0 next edge; all outputs 0; a new 01,0B command then produces a complete frame.
REQ-038 Bench SHALL cover: stray bytes 7F, 00 in IDLE and bytes during WAIT_RESP -> ignored; puf_done coincident with timeout -> good frame sent, err_timeout=0.
